alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Initiator-side driver for the team's registered ALU.
- Accepts operation requests from an upstream controller through a valid/ready handshake and buffers them in an in-order FIFO.
- Drives the ALU's operand, command and enable lines, waits the ALU's pipeline latency, captures RES and flags, and returns them with the request tag on a valid/ready response channel.
- Sits between the system controller and the ALU instance; the only agent driving the ALU ports.

Parameters:
- WIDTH, 8: operand width; must match ALU width.
- CMD_WIDTH, 4: command field width.
- TAG_W, 4: request tag width, echoed on the response.
- DEPTH, 4: request FIFO depth (power of 2, ≥2).
- ALU_LAT, 2: cycles from the ALU issue cycle to valid RES for normal ops.
- MUL_LAT, 3: same, for multiply ops (MODE=1, CMD=9 or 10).

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when both high
- req_opa  in  WIDTH  operand A
- req_opb  in  WIDTH  operand B
- req_cmd  in  CMD_WIDTH  ALU command
- req_mode  in  1  1=arithmetic, 0=logical
- req_cin  in  1  carry in
- req_inp_valid  in  2  operand-valid code passed to ALU
- req_tag  in  TAG_W  request identifier
- alu_opa, alu_opb  out  WIDTH  to ALU OPA/OPB
- alu_cmd  out  CMD_WIDTH  to ALU CMD
- alu_mode, alu_cin, alu_ce  out  1  to ALU MODE/CIN/CE
- alu_inp_valid  out  2  to ALU INP_VALID
- alu_res  in  2*WIDTH+1  from ALU RES
- alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err  in  1  ALU flags
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when both high
- rsp_res  out  2*WIDTH+1  captured RES
- rsp_flags  out  6  {cout,oflow,g,e,l,err}
- rsp_tag  out  TAG_W  tag of the completed request
- busy  out  1  FSM not IDLE or FIFO not empty

Behaviour:
- Reset (async, RST=1): FSM→IDLE; FIFO emptied; all outputs 0 except req_ready=1. Covers alu_*, rsp_*, busy. An in-flight op is discarded and produces no response.
- FIFO:
  - Push on req_valid&&req_ready; req_ready = !full (registered full flag).
  - Pop only when the FSM leaves IDLE for ISSUE.
  - Pointers wrap modulo DEPTH; a count of 0..DEPTH distinguishes full from empty.
  - Push and pop in the same cycle leaves the count unchanged.
  - A push is never accepted while full, even if a pop occurs that cycle.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: alu_ce=0. If FIFO not empty → ISSUE; pop head into the op register.
  - ISSUE (1 cycle): alu_* driven from the op register, alu_ce=1. Latency counter loaded with LAT-1, where LAT=MUL_LAT if mode=1 and cmd∈{9,10}, else ALU_LAT. → WAIT.
  - WAIT: alu_* held stable, alu_ce=1, counter decrements. At the edge where the counter is 0, capture alu_res and flags into rsp_*, set rsp_valid=1 → RESP.
  - RESP: alu_ce=0, alu_* held. On rsp_valid&&rsp_ready: rsp_valid←0. Then → ISSUE directly if FIFO not empty (pop), else → IDLE. rsp_* data held stable while rsp_valid=1 and rsp_ready=0.
- Latency: a request accepted into an empty FIFO while IDLE reaches ISSUE in the next cycle. rsp_valid rises LAT+2 edges after the accept edge. Back-to-back throughput is one op per LAT+2 cycles with rsp_ready held high.
- Responses are strictly in request order. Exactly one op is in flight at a time.
- Width: rsp_res is the ALU RES passed through unmodified; no sign or zero handling in this block.
- ALU ERR is passed through in rsp_flags[0]; the sequencer never suppresses or retries.
- busy = (state!=IDLE) || !empty.

Optional Feature:
- Macro: ALU_SEQ_ERR_CNT_EN.
- When defined: adds output err_cnt[7:0], an 8-bit saturating counter (stops at 255) incremented on each response handshake whose err flag=1. Reset to 0.
- When undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Add timing: MODE=1 CMD=0 OPA=0x0F OPB=0x01 INP_VALID=3 tag=5, rsp_ready=1 → rsp_valid exactly 4 edges after accept, rsp_res=0x010, cout=0, err=0, tag=5.
- Multiply latency: MODE=1 CMD=9 OPA=3 OPB=4 INP_VALID=3 → rsp_res=20 (0x014), rsp_valid 5 edges after accept.
- FIFO full and ordering: rsp_ready=0, push 6 requests tags 0..5 → 5 accepted (1 in RESP + 4 queued), req_ready=0 on the 6th. Release rsp_ready → tags 0,1,2,3,4 in order, rsp_* stable while stalled.
- Error passthrough: MODE=1 CMD=0 INP_VALID=1 → rsp_res=0, err=1. With ALU_SEQ_ERR_CNT_EN, err_cnt=1.
- Compare: MODE=1 CMD=8 OPA=5 OPB=9 INP_VALID=3 → l=1, g=0, e=0, rsp_res=0.
- Reset mid-op: assert RST during WAIT → all outputs 0 immediately, req_ready=1, FIFO empty. No response is ever produced for the aborted tag.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU requests in an in-order FIFO, issues them one at a time to the registered ALU,
// and returns RES/flags with the request tag. Optional error counter: define ALU_SEQ_ERR_CNT_EN.
module alu_cmd_sequencer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CMD_WIDTH = 4,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ALU_LAT   = 2,
  parameter int unsigned MUL_LAT   = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WIDTH-1:0]     req_opa,
  input  logic [WIDTH-1:0]     req_opb,
  input  logic [CMD_WIDTH-1:0] req_cmd,
  input  logic                 req_mode,
  input  logic                 req_cin,
  input  logic [1:0]           req_inp_valid,
  input  logic [TAG_W-1:0]     req_tag,
  output logic [WIDTH-1:0]     alu_opa,
  output logic [WIDTH-1:0]     alu_opb,
  output logic [CMD_WIDTH-1:0] alu_cmd,
  output logic                 alu_mode,
  output logic                 alu_cin,
  output logic                 alu_ce,
  output logic [1:0]           alu_inp_valid,
  input  logic [2*WIDTH:0]     alu_res,
  input  logic                 alu_cout,
  input  logic                 alu_oflow,
  input  logic                 alu_g,
  input  logic                 alu_e,
  input  logic                 alu_l,
  input  logic                 alu_err,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*WIDTH:0]     rsp_res,
  output logic [5:0]           rsp_flags,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic                 busy
`ifdef ALU_SEQ_ERR_CNT_EN
  , output logic [7:0]         err_cnt
`endif
);

  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LAT_MAX = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
  localparam int unsigned CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX + 1) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0]     opa;
    logic [WIDTH-1:0]     opb;
    logic [CMD_WIDTH-1:0] cmd;
    logic                 mode;
    logic                 cin;
    logic [1:0]           inp_valid;
    logic [TAG_W-1:0]     tag;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  req_t               fifo_mem [DEPTH];
  req_t               req_in, op_q;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count, count_nxt;
  logic               full_q, empty, push, pop;
  logic               capture, rsp_done, is_mul;
  logic [CNT_W-1:0]   lat_cnt, lat_load;
  logic               rsp_valid_q;
  logic [2*WIDTH:0]   rsp_res_q;
  logic [5:0]         rsp_flags_q;
  logic [TAG_W-1:0]   rsp_tag_q;

  assign req_in = '{opa: req_opa, opb: req_opb, cmd: req_cmd, mode: req_mode,
                    cin: req_cin, inp_valid: req_inp_valid, tag: req_tag};

  assign empty     = (count == '0);
  assign req_ready = !full_q;
  assign push      = req_valid && !full_q;
  assign rsp_done  = rsp_valid_q && rsp_ready;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + {{PTR_W{1'b0}}, 1'b1};
      2'b01:   count_nxt = count - {{PTR_W{1'b0}}, 1'b1};
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= req_in;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
      count  <= count_nxt;
      full_q <= (count_nxt == FULL_CNT);
    end
  end

  always_comb begin
    is_mul   = op_q.mode && ((op_q.cmd == CMD_WIDTH'(9)) || (op_q.cmd == CMD_WIDTH'(10)));
    lat_load = is_mul ? CNT_W'(MUL_LAT - 1) : CNT_W'(ALU_LAT - 1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // RESP can chain straight into ISSUE so back-to-back ops cost LAT+2 cycles.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (lat_cnt == '0) begin
          capture = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_done) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_q        <= '0;
      lat_cnt     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_res_q   <= '0;
      rsp_flags_q <= '0;
      rsp_tag_q   <= '0;
    end else begin
      if (pop) op_q <= fifo_mem[rd_ptr];
      if (state_q == S_ISSUE)
        lat_cnt <= lat_load;
      else if ((state_q == S_WAIT) && (lat_cnt != '0))
        lat_cnt <= lat_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
      if (capture) begin
        rsp_valid_q <= 1'b1;
        rsp_res_q   <= alu_res;
        rsp_flags_q <= {alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err};
        rsp_tag_q   <= op_q.tag;
      end else if (rsp_done) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_ERR_CNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      err_cnt <= '0;
    else if (rsp_done && rsp_flags_q[0] && (err_cnt != '1))
      err_cnt <= err_cnt + 8'd1;
  end
`endif

  assign alu_opa       = op_q.opa;
  assign alu_opb       = op_q.opb;
  assign alu_cmd       = op_q.cmd;
  assign alu_mode      = op_q.mode;
  assign alu_cin       = op_q.cin;
  assign alu_inp_valid = op_q.inp_valid;
  assign alu_ce        = (state_q == S_ISSUE) || (state_q == S_WAIT);

  assign rsp_valid = rsp_valid_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_tag   = rsp_tag_q;
  assign busy      = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small registered-ALU model (2-cycle normal, 3-cycle multiply).
module tb_alu_cmd_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_opa = '0, req_opb = '0;
  logic [3:0]  req_cmd = '0;
  logic        req_mode = 1'b0, req_cin = 1'b0;
  logic [1:0]  req_inp_valid = '0;
  logic [3:0]  req_tag = '0;
  logic [7:0]  alu_opa, alu_opb;
  logic [3:0]  alu_cmd;
  logic        alu_mode, alu_cin, alu_ce;
  logic [1:0]  alu_inp_valid;
  logic [16:0] alu_res;
  logic        alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [16:0] rsp_res;
  logic [5:0]  rsp_flags;
  logic [3:0]  rsp_tag;
  logic        busy;
`ifdef ALU_SEQ_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 CLK = ~CLK;

  alu_cmd_sequencer #(
    .WIDTH(8), .CMD_WIDTH(4), .TAG_W(4), .DEPTH(4), .ALU_LAT(2), .MUL_LAT(3)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_opb(req_opb), .req_cmd(req_cmd),
    .req_mode(req_mode), .req_cin(req_cin), .req_inp_valid(req_inp_valid), .req_tag(req_tag),
    .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_cmd(alu_cmd),
    .alu_mode(alu_mode), .alu_cin(alu_cin), .alu_ce(alu_ce), .alu_inp_valid(alu_inp_valid),
    .alu_res(alu_res), .alu_cout(alu_cout), .alu_oflow(alu_oflow),
    .alu_g(alu_g), .alu_e(alu_e), .alu_l(alu_l), .alu_err(alu_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
    .busy(busy)
`ifdef ALU_SEQ_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  // ALU model: returns {cout,oflow,g,e,l,err,res[16:0]}
  function automatic logic [22:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] cmd, input logic mode,
                                            input logic [1:0] iv);
    logic [16:0] res;
    logic [5:0]  fl;
    logic [15:0] prod;
    res = '0;
    fl  = '0;
    if (mode) begin
      if ((iv != 2'b11) && ((cmd == 4'd0) || (cmd == 4'd8) || (cmd == 4'd9))) begin
        fl[0] = 1'b1;
      end else begin
        case (cmd)
          4'd0: begin
            res   = {8'd0, {1'b0, a} + {1'b0, b}};
            fl[5] = res[8];
          end
          4'd8: begin
            fl[3] = (a > b);
            fl[2] = (a == b);
            fl[1] = (a < b);
          end
          4'd9: begin
            prod = ({8'd0, a} + 16'd1) * ({8'd0, b} + 16'd1);
            res  = {1'b0, prod};
          end
          default: res = '0;
        endcase
      end
    end
    return {fl, res};
  endfunction

  logic [22:0] p1 = '0, p2 = '0, p3 = '0, alu_sel;
  always @(posedge CLK) begin
    if (alu_ce) begin
      p1 <= alu_model(alu_opa, alu_opb, alu_cmd, alu_mode, alu_inp_valid);
      p2 <= p1;
      p3 <= p2;
    end
  end
  always_comb begin
    alu_sel = (alu_mode && ((alu_cmd == 4'd9) || (alu_cmd == 4'd10))) ? p3 : p2;
    {alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err} = alu_sel[22:17];
    alu_res = alu_sel[16:0];
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] cmd,
                      input logic mode, input logic [1:0] iv, input logic [3:0] tag);
    int unsigned guard;
    guard = 0;
    @(negedge CLK);
    req_opa = a; req_opb = b; req_cmd = cmd; req_mode = mode; req_cin = 1'b0;
    req_inp_valid = iv; req_tag = tag; req_valid = 1'b1;
    while (!req_ready && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_accept tag=%0d: req_ready=%b required 1", tag, req_ready);
    end
    @(posedge CLK);
    #1 req_valid = 1'b0;
  endtask

  // Called right after an accept edge (+1); counts edges until rsp_valid is seen.
  task automatic wait_rsp(output int unsigned edges);
    edges = 1;
    while (!rsp_valid && edges < 20) begin
      @(posedge CLK);
      #1;
      if (!rsp_valid) edges++;
    end
    if (!rsp_valid) edges = 99;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
    n_checks++;
    if ({rsp_valid, alu_ce, busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: {rsp_valid,alu_ce,busy}=%b required 000", {rsp_valid, alu_ce, busy});
    end
    n_checks++;
    if ({alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_inp_valid} !== 24'd0) begin
      n_fail++; $display("FAIL reset_alu_bus: got %h required 0", {alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_inp_valid});
    end
    n_checks++;
    if ({rsp_res, rsp_flags, rsp_tag} !== 27'd0) begin
      n_fail++; $display("FAIL reset_rsp_bus: got %h required 0", {rsp_res, rsp_flags, rsp_tag});
    end
`ifdef ALU_SEQ_ERR_CNT_EN
    n_checks++;
    if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d required 0", err_cnt); end
`endif
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_add_timing();
    int unsigned e;
    rsp_ready = 1'b1;
    send(8'h0F, 8'h01, 4'd0, 1'b1, 2'b11, 4'd5);
    wait_rsp(e);
    n_checks++;
    if (e != 4) begin n_fail++; $display("FAIL add_latency: rsp_valid after %0d edges required 4", e); end
    n_checks++;
    if (rsp_res !== 17'h010) begin n_fail++; $display("FAIL add_res: got %h required 010", rsp_res); end
    n_checks++;
    if (rsp_flags !== 6'b000000) begin n_fail++; $display("FAIL add_flags: got %b required 000000", rsp_flags); end
    n_checks++;
    if (rsp_tag !== 4'd5) begin n_fail++; $display("FAIL add_tag: got %0d required 5", rsp_tag); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL add_busy: got %b required 1", busy); end
    @(posedge CLK);
    #1;
    n_checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL add_after_handshake: {rsp_valid,busy}=%b required 00", {rsp_valid, busy});
    end
  endtask

  task automatic test_mul_latency();
    int unsigned e;
    send(8'd3, 8'd4, 4'd9, 1'b1, 2'b11, 4'd6);
    wait_rsp(e);
    n_checks++;
    if (e != 5) begin n_fail++; $display("FAIL mul_latency: rsp_valid after %0d edges required 5", e); end
    n_checks++;
    if (rsp_res !== 17'h014) begin n_fail++; $display("FAIL mul_res: got %h required 014", rsp_res); end
    n_checks++;
    if (rsp_tag !== 4'd6) begin n_fail++; $display("FAIL mul_tag: got %0d required 6", rsp_tag); end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_fifo_full_order();
    logic        rdy;
    int unsigned got, last_cyc, cyc;
    rsp_ready = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      @(negedge CLK);
      req_opa = 8'h10 + 8'(i); req_opb = 8'(i); req_cmd = 4'd0; req_mode = 1'b1;
      req_inp_valid = 2'b11; req_tag = 4'(i); req_valid = 1'b1;
      rdy = req_ready;
      n_checks++;
      if (rdy !== (i < 5)) begin
        n_fail++; $display("FAIL fifo_req_ready push%0d: got %b required %b", i, rdy, (i < 5));
      end
      @(posedge CLK);
    end
    @(negedge CLK);
    req_valid = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      n_checks++;
      if ({rsp_valid, rsp_tag, rsp_res} !== {1'b1, 4'd0, 17'h010}) begin
        n_fail++; $display("FAIL fifo_stall_hold cyc%0d: valid=%b tag=%0d res=%h required 1/0/010", k, rsp_valid, rsp_tag, rsp_res);
      end
      @(negedge CLK);
    end
    rsp_ready = 1'b1;
    got = 0;
    last_cyc = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      if (rsp_valid) begin
        n_checks++;
        if (rsp_tag !== 4'(got) || rsp_res !== (17'h010 + 17'(2 * got))) begin
          n_fail++; $display("FAIL fifo_order rsp%0d: tag=%0d res=%h required tag=%0d res=%h", got, rsp_tag, rsp_res, got, 17'h010 + 17'(2 * got));
        end
        if (got > 0) begin
          n_checks++;
          if (cyc - last_cyc != 4) begin
            n_fail++; $display("FAIL b2b_interval rsp%0d: %0d cycles required 4", got, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        got++;
      end
      @(negedge CLK);
    end
    n_checks++;
    if (got != 5) begin n_fail++; $display("FAIL fifo_rsp_count: got %0d required 5", got); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL fifo_drained_busy: got %b required 0", busy); end
  endtask

  task automatic test_error();
    int unsigned e;
    send(8'h22, 8'h33, 4'd0, 1'b1, 2'b01, 4'd9);
    wait_rsp(e);
    n_checks++;
    if (e != 4) begin n_fail++; $display("FAIL err_latency: %0d edges required 4", e); end
    n_checks++;
    if (rsp_res !== 17'd0 || rsp_flags !== 6'b000001) begin
      n_fail++; $display("FAIL err_passthrough: res=%h flags=%b required 0/000001", rsp_res, rsp_flags);
    end
    @(posedge CLK);
    #1;
`ifdef ALU_SEQ_ERR_CNT_EN
    n_checks++;
    if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL err_cnt: got %0d required 1", err_cnt); end
`endif
  endtask

  task automatic test_compare();
    int unsigned e;
    send(8'd5, 8'd9, 4'd8, 1'b1, 2'b11, 4'd10);
    wait_rsp(e);
    n_checks++;
    if (rsp_flags !== 6'b000010 || rsp_res !== 17'd0 || rsp_tag !== 4'd10) begin
      n_fail++; $display("FAIL cmp_lt: flags=%b res=%h tag=%0d required 000010/0/10", rsp_flags, rsp_res, rsp_tag);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset_mid_op();
    logic saw;
    rsp_ready = 1'b1;
    @(negedge CLK);
    req_opa = 8'h01; req_opb = 8'h02; req_cmd = 4'd0; req_mode = 1'b1;
    req_inp_valid = 2'b11; req_tag = 4'd7; req_valid = 1'b1;
    @(negedge CLK);
    req_tag = 4'd8;
    @(negedge CLK);
    req_valid = 1'b0;
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    n_checks++;
    if ({rsp_valid, alu_ce, busy, req_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL midreset_ctrl: {rsp_valid,alu_ce,busy,req_ready}=%b required 0001", {rsp_valid, alu_ce, busy, req_ready});
    end
    n_checks++;
    if ({alu_opa, alu_opb, alu_cmd, alu_mode, alu_inp_valid} !== 23'd0) begin
      n_fail++; $display("FAIL midreset_alu_bus: got %h required 0", {alu_opa, alu_opb, alu_cmd, alu_mode, alu_inp_valid});
    end
    @(negedge CLK);
    RST = 1'b0;
    saw = 1'b0;
    repeat (20) begin
      @(negedge CLK);
      if (rsp_valid || busy) saw = 1'b1;
    end
    n_checks++;
    if (saw !== 1'b0) begin n_fail++; $display("FAIL midreset_no_rsp: activity seen=%b required 0", saw); end
  endtask

  initial begin
    test_reset();
    test_add_timing();
    test_mul_latency();
    test_fifo_full_order();
    test_error();
    test_compare();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
